// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for the 2-way set-associative L2 cache.
// Drives the tag/valid/dirty/LRU/data array strobes and sequences miss
// handling (optional dirty writeback, then line fetch) toward physical memory.
// The line data moves through the datapath; this block only selects the way
// and the data source.
//
// state     | meaning
// IDLE      | waiting for an upstream request; array read at the request index
// COMPARE   | tag compare on array outputs; hit completes, miss picks a victim
// WRITEBACK | dirty victim line being written to pmem
// FETCH     | requested line being read from pmem and loaded into the victim way
module l2_cache_control #(
  parameter int s_index  = 3,
  parameter int s_offset = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_read,
  input  logic                       mem_write,
  input  logic [31:0]                mem_address,
  output logic                       mem_resp,
  output logic                       arr_read,
  output logic [s_index-1:0]         arr_rindex,
  output logic [s_index-1:0]         arr_windex,
  input  logic [2*(32-s_index-s_offset)-1:0] tag_out,
  input  logic [1:0]                 valid_out,
  input  logic [1:0]                 dirty_out,
  input  logic                       lru_out,
  output logic [1:0]                 tag_load,
  output logic [32-s_index-s_offset-1:0] tag_in,
  output logic [1:0]                 valid_load,
  output logic                       valid_in,
  output logic [1:0]                 dirty_load,
  output logic                       dirty_in,
  output logic                       lru_load,
  output logic                       lru_in,
  output logic [1:0]                 data_load,
  output logic                       data_way,
  output logic                       data_src,
  output logic                       pmem_read,
  output logic                       pmem_write,
  output logic [31:0]                pmem_address,
  input  logic                       pmem_resp
);

  localparam int s_tag = 32 - s_index - s_offset;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    FETCH     = 2'd3
  } state_t;

  state_t state;

  // Only the line address (tag + index) of the request is kept; the offset
  // bits never matter to the controller.
  logic [31:s_offset] line_q;
  logic               write_q;
  logic               victim_q;

  logic [s_index-1:0] idx_q;
  logic [s_tag-1:0]   tag_q;
  logic [s_index-1:0] req_idx;
  logic [s_tag-1:0]   tag_way0;
  logic [s_tag-1:0]   tag_way1;
  logic [s_tag-1:0]   victim_tag;
  logic [1:0]         hit;
  logic               hit_way;
  logic               victim_c;
  logic               unused_offset;

  assign idx_q      = line_q[s_offset +: s_index];
  assign tag_q      = line_q[31 -: s_tag];
  assign req_idx    = mem_address[s_offset +: s_index];
  assign tag_way0   = tag_out[0 +: s_tag];
  assign tag_way1   = tag_out[s_tag +: s_tag];
  assign victim_tag = victim_q ? tag_way1 : tag_way0;

  assign hit[0]  = valid_out[0] & (tag_way0 == tag_q);
  assign hit[1]  = valid_out[1] & (tag_way1 == tag_q);
  // A legal array never holds the same tag twice in a set; way 0 wins if it does.
  assign hit_way = ~hit[0];

  // Fill an invalid way before evicting anything; otherwise follow LRU.
  assign victim_c = !valid_out[0] ? 1'b0 :
                    !valid_out[1] ? 1'b1 : lru_out;

  assign unused_offset = ^mem_address[s_offset-1:0];

  // State register plus the latched request line, op and victim way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      line_q   <= '0;
      write_q  <= 1'b0;
      victim_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_read | mem_write) begin
            line_q  <= mem_address[31:s_offset];
            write_q <= mem_write;
            state   <= COMPARE;
          end
        end
        COMPARE: begin
          if (|hit) begin
            state <= IDLE;
          end else begin
            victim_q <= victim_c;
            if (valid_out[victim_c] & dirty_out[victim_c])
              state <= WRITEBACK;
            else
              state <= FETCH;
          end
        end
        WRITEBACK: begin
          if (pmem_resp)
            state <= FETCH;
        end
        FETCH: begin
          if (pmem_resp)
            state <= COMPARE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array strobes and memory requests; everything held at 0 while in reset so
  // an in-flight pmem request drops the moment rst falls.
  always_comb begin
    mem_resp     = 1'b0;
    arr_read     = 1'b0;
    arr_rindex   = '0;
    arr_windex   = '0;
    tag_load     = 2'b00;
    tag_in       = '0;
    valid_load   = 2'b00;
    valid_in     = 1'b0;
    dirty_load   = 2'b00;
    dirty_in     = 1'b0;
    lru_load     = 1'b0;
    lru_in       = 1'b0;
    data_load    = 2'b00;
    data_way     = 1'b0;
    data_src     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    if (rst) begin
      case (state)
        IDLE: begin
          arr_read   = 1'b1;
          arr_rindex = req_idx;
        end
        COMPARE: begin
          arr_rindex = idx_q;
          arr_windex = idx_q;
          if (|hit) begin
            data_way = hit_way;
            lru_load = 1'b1;
            lru_in   = ~hit_way;
            mem_resp = 1'b1;
            if (write_q) begin
              data_load[hit_way]  = 1'b1;
              data_src            = 1'b0;
              dirty_load[hit_way] = 1'b1;
              dirty_in            = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          arr_rindex   = idx_q;
          arr_windex   = idx_q;
          pmem_write   = 1'b1;
          pmem_address = {victim_tag, idx_q, {s_offset{1'b0}}};
          data_way     = victim_q;
        end
        FETCH: begin
          arr_rindex   = idx_q;
          arr_windex   = idx_q;
          pmem_read    = 1'b1;
          pmem_address = {tag_q, idx_q, {s_offset{1'b0}}};
          data_way     = victim_q;
          if (pmem_resp) begin
            // Refill the victim way and re-read the set in the same cycle so
            // COMPARE sees the new line through array forwarding.
            data_load[victim_q]  = 1'b1;
            data_src             = 1'b1;
            tag_load[victim_q]   = 1'b1;
            tag_in               = tag_q;
            valid_load[victim_q] = 1'b1;
            valid_in             = 1'b1;
            dirty_load[victim_q] = 1'b1;
            dirty_in             = 1'b0;
            arr_read             = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_cache_control.sv
// Bench for l2_cache_control: behavioural array model driven by the DUT's
// strobes, plus an abstract cache model (tags/valid/dirty/LRU per set) that
// predicts hit/miss, victim, writeback and refill for each request.
module tb_l2_cache_control;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] mem_address = '0;
  logic        mem_resp;
  logic        arr_read;
  logic [2:0]  arr_rindex;
  logic [2:0]  arr_windex;
  logic [47:0] tag_out = '0;
  logic [1:0]  valid_out = '0;
  logic [1:0]  dirty_out = '0;
  logic        lru_out = 1'b0;
  logic [1:0]  tag_load;
  logic [23:0] tag_in;
  logic [1:0]  valid_load;
  logic        valid_in;
  logic [1:0]  dirty_load;
  logic        dirty_in;
  logic        lru_load;
  logic        lru_in;
  logic [1:0]  data_load;
  logic        data_way;
  logic        data_src;
  logic        pmem_read;
  logic        pmem_write;
  logic [31:0] pmem_address;
  logic        pmem_resp = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  l2_cache_control #(.s_index(3), .s_offset(5)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_resp(mem_resp), .arr_read(arr_read), .arr_rindex(arr_rindex),
    .arr_windex(arr_windex), .tag_out(tag_out), .valid_out(valid_out),
    .dirty_out(dirty_out), .lru_out(lru_out), .tag_load(tag_load),
    .tag_in(tag_in), .valid_load(valid_load), .valid_in(valid_in),
    .dirty_load(dirty_load), .dirty_in(dirty_in), .lru_load(lru_load),
    .lru_in(lru_in), .data_load(data_load), .data_way(data_way),
    .data_src(data_src), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Array storage seen by the DUT (not reset by rst; it is a separate block).
  logic [7:0][1:0][23:0] a_tag   = '0;
  logic [7:0][1:0]       a_valid = '0;
  logic [7:0][1:0]       a_dirty = '0;
  logic [7:0]            a_lru   = '0;

  // 1-cycle read latency, same-index load+read forwards the new value.
  always @(posedge clk) begin
    for (int w = 0; w < 2; w++) begin
      if (tag_load[w])   a_tag[arr_windex][w]   <= tag_in;
      if (valid_load[w]) a_valid[arr_windex][w] <= valid_in;
      if (dirty_load[w]) a_dirty[arr_windex][w] <= dirty_in;
    end
    if (lru_load) a_lru[arr_windex] <= lru_in;
    if (arr_read) begin
      for (int w = 0; w < 2; w++) begin
        tag_out[w*24 +: 24] <= (tag_load[w] && arr_windex == arr_rindex) ? tag_in : a_tag[arr_rindex][w];
        valid_out[w] <= (valid_load[w] && arr_windex == arr_rindex) ? valid_in : a_valid[arr_rindex][w];
        dirty_out[w] <= (dirty_load[w] && arr_windex == arr_rindex) ? dirty_in : a_dirty[arr_rindex][w];
      end
      lru_out <= (lru_load && arr_windex == arr_rindex) ? lru_in : a_lru[arr_rindex];
    end
  end

  // Reference cache contents.
  logic [23:0] ref_tag   [8][2];
  bit          ref_valid [8][2];
  bit          ref_dirty [8][2];
  bit          ref_lru   [8];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One pmem phase (writeback or fetch): request held, pmem_resp after lat cycles.
  task automatic serve(input bit is_fetch, input logic [31:0] exp_addr, input bit v,
                       input logic [2:0] set, input logic [23:0] tg, input int lat);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      if (c == lat - 1) pmem_resp = 1'b1;
      #1;
      check(is_fetch ? "fetch_req" : "wb_req", is_fetch ? pmem_read : pmem_write, 1);
      check(is_fetch ? "fetch_no_wr" : "wb_no_rd", is_fetch ? pmem_write : pmem_read, 0);
      check(is_fetch ? "fetch_addr" : "wb_addr", pmem_address, exp_addr);
      check("pmem_data_way", data_way, v);
      check("miss_no_resp", mem_resp, 0);
      if (is_fetch && c == lat - 1) begin
        check("refill_tag_load", tag_load, 2'b01 << v);
        check("refill_tag_in", tag_in, tg);
        check("refill_valid", {valid_load, valid_in}, {2'b01 << v, 1'b1});
        check("refill_dirty", {dirty_load, dirty_in}, {2'b01 << v, 1'b0});
        check("refill_data", {data_load, data_src}, {2'b01 << v, 1'b1});
        check("refill_rd", {arr_read, arr_rindex, arr_windex}, {1'b1, set, set});
      end else begin
        check("pmem_no_load", {tag_load, data_load, arr_read}, 0);
      end
    end
    @(posedge clk);
    #1 pmem_resp = 1'b0;
  endtask

  task automatic do_req(input logic [31:0] addr, input bit rd, input bit wr, input int lat);
    logic [2:0]  set;
    logic [23:0] tg;
    int          hitw;
    bit          v;
    bit          w;
    set  = addr[7:5];
    tg   = addr[31:8];
    hitw = -1;
    for (int i = 1; i >= 0; i--)
      if (ref_valid[set][i] && ref_tag[set][i] == tg) hitw = i;

    @(negedge clk);
    mem_address = addr;
    mem_read    = rd;
    mem_write   = wr;
    #1;
    check("idle_read", {arr_read, arr_rindex}, {1'b1, set});
    check("idle_no_resp", {mem_resp, pmem_read, pmem_write}, 0);

    @(negedge clk); #1;
    if (hitw < 0) begin
      check("cmp_miss_no_resp", {mem_resp, lru_load, data_load}, 0);
      v = !ref_valid[set][0] ? 1'b0 : !ref_valid[set][1] ? 1'b1 : ref_lru[set];
      if (ref_valid[set][v] && ref_dirty[set][v])
        serve(1'b0, {ref_tag[set][v], set, 5'b0}, v, set, tg, lat);
      serve(1'b1, {tg, set, 5'b0}, v, set, tg, lat);
      ref_tag[set][v]   = tg;
      ref_valid[set][v] = 1'b1;
      ref_dirty[set][v] = 1'b0;
      @(negedge clk); #1;
      w = v;
    end else begin
      w = hitw[0];
    end
    check("hit_resp", mem_resp, 1);
    check("hit_way", data_way, w);
    check("hit_lru", {lru_load, lru_in}, {1'b1, ~w});
    check("hit_data_load", data_load, wr ? (2'b01 << w) : 2'b00);
    check("hit_dirty", {dirty_load, dirty_in}, wr ? {2'b01 << w, 1'b1} : 3'b000);
    check("hit_no_pmem", {pmem_read, pmem_write}, 0);
    if (wr) check("hit_src", data_src, 0);
    ref_lru[set] = ~w;
    if (wr) ref_dirty[set][w] = 1'b1;
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    for (int s = 0; s < 8; s++) begin
      ref_lru[s] = 1'b0;
      for (int w = 0; w < 2; w++) begin
        ref_tag[s][w] = '0; ref_valid[s][w] = 1'b0; ref_dirty[s][w] = 1'b0;
      end
    end

    // Outputs forced low under reset even with a request pending.
    mem_read = 1'b1;
    mem_address = 32'h0000_1000;
    #12;
    check("rst_outputs", {mem_resp, arr_read, pmem_read, pmem_write, lru_load, data_load}, 0);
    mem_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 check("post_rst_idle", {arr_read, mem_resp}, 2'b10);

    // Cold read, repeat hit, fill way1, write hit in way1.
    do_req(32'h0000_1000, 1, 0, 3);
    do_req(32'h0000_1000, 1, 0, 3);
    do_req(32'h0000_1100, 1, 0, 2);
    do_req(32'h0000_1104, 0, 1, 2);
    // Dirty eviction: way0 tag 0x12 dirty, way1 tag 0x13, LRU points to way0.
    do_req(32'h0000_1240, 0, 1, 1);
    do_req(32'h0000_1340, 1, 0, 1);
    do_req(32'h0000_1440, 1, 0, 2);
    // Read and write together on a hit behave as a write.
    do_req(32'h0000_1000, 1, 1, 1);

    // Reset dropped in the middle of a fetch.
    @(negedge clk);
    mem_address = 32'h0000_7760; mem_read = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    check("midrst_fetching", pmem_read, 1);
    rst = 1'b0;
    #1 check("midrst_drop", {pmem_read, pmem_write, mem_resp, arr_read}, 0);
    mem_read = 1'b0;
    @(negedge clk); rst = 1'b1;
    #1 check("midrst_idle", {arr_read, mem_resp, pmem_read}, 3'b100);
    @(negedge clk); #1;
    check("midrst_no_resp", {arr_read, mem_resp, pmem_read}, 3'b100);

    // Randomized traffic over a small tag space to mix hits, clean and dirty misses.
    for (int n = 0; n < 200; n++) begin
      logic [31:0] a;
      int          op;
      a  = {8'h00, 16'($urandom_range(0, 5)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
      op = $urandom_range(0, 2);
      do_req(a, op != 1, op != 0, $urandom_range(1, 4));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
